// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP responder oversampled on clk (IDCODE, BYPASS, USER DR).
// Define JTAG_TAP_GLITCH_FILTER_EN to add a third tck stage that rejects single-clk tck pulses.
module jtag_tap_sampled #(
  parameter int unsigned IR_WIDTH = 5,
  parameter int unsigned DR_WIDTH = 32,
  parameter logic [31:0] IDCODE   = 32'h1000_0E1F
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  input  logic                trst,
  output logic                tdo,
  output logic                tdo_en,
  input  logic [DR_WIDTH-1:0] cap_data,
  output logic                cap_strobe,
  output logic [DR_WIDTH-1:0] upd_data,
  output logic                upd_valid
);

  localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(5'h01);
  localparam logic [IR_WIDTH-1:0] IrUser   = IR_WIDTH'(5'h11);

  typedef enum logic [3:0] {
    StTlr   = 4'hF,
    StRti   = 4'hC,
    StSelDr = 4'h7,
    StCapDr = 4'h6,
    StShDr  = 4'h2,
    StEx1Dr = 4'h1,
    StPaDr  = 4'h3,
    StEx2Dr = 4'h0,
    StUpdDr = 4'h5,
    StSelIr = 4'h4,
    StCapIr = 4'hE,
    StShIr  = 4'hA,
    StEx1Ir = 4'h9,
    StPaIr  = 4'hB,
    StEx2Ir = 4'h8,
    StUpdIr = 4'hD
  } tap_state_e;

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic [1:0] r_tck_sync, r_tms_sync, r_tdi_sync, r_trst_sync;
  logic       w_tck, w_tms, w_tdi, w_trst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tck_sync  <= '0;
      r_tms_sync  <= '0;
      r_tdi_sync  <= '0;
      r_trst_sync <= '0;
    end else begin
      r_tck_sync  <= {r_tck_sync[0], tck};
      r_tms_sync  <= {r_tms_sync[0], tms};
      r_tdi_sync  <= {r_tdi_sync[0], tdi};
      r_trst_sync <= {r_trst_sync[0], trst};
    end
  end

  assign w_trst = r_trst_sync[1];

`ifdef JTAG_TAP_GLITCH_FILTER_EN
  logic r_tck_filt, r_tms_s3, r_tdi_s3;

  // tck only moves once both upstream stages agree, so a 1-clk pulse never propagates
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tck_filt <= 1'b0;
      r_tms_s3   <= 1'b0;
      r_tdi_s3   <= 1'b0;
    end else begin
      if (r_tck_sync[1] == r_tck_sync[0]) r_tck_filt <= r_tck_sync[1];
      r_tms_s3 <= r_tms_sync[1];
      r_tdi_s3 <= r_tdi_sync[1];
    end
  end

  assign w_tck = r_tck_filt;
  assign w_tms = r_tms_s3;
  assign w_tdi = r_tdi_s3;
`else
  assign w_tck = r_tck_sync[1];
  assign w_tms = r_tms_sync[1];
  assign w_tdi = r_tdi_sync[1];
`endif

  // ---------------------------------------------------------------------------
  // Edge detection; events are registered together with the tms/tdi they use
  // ---------------------------------------------------------------------------
  logic r_tck_prev, r_rise, r_fall, r_tms_ev, r_tdi_ev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tck_prev <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_tms_ev   <= 1'b0;
      r_tdi_ev   <= 1'b0;
    end else begin
      r_tck_prev <= w_tck;
      r_tms_ev   <= w_tms;
      r_tdi_ev   <= w_tdi;
      if (w_trst) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_tck & ~r_tck_prev;
        r_fall <= ~w_tck & r_tck_prev;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TAP FSM: state register
  // ---------------------------------------------------------------------------
  tap_state_e r_state, w_state_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StTlr;
    end else if (w_trst) begin
      r_state <= StTlr;
    end else if (r_rise) begin
      r_state <= w_state_next;
    end
  end

  // TAP FSM: next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StTlr:   w_state_next = r_tms_ev ? StTlr   : StRti;
      StRti:   w_state_next = r_tms_ev ? StSelDr : StRti;
      StSelDr: w_state_next = r_tms_ev ? StSelIr : StCapDr;
      StCapDr: w_state_next = r_tms_ev ? StEx1Dr : StShDr;
      StShDr:  w_state_next = r_tms_ev ? StEx1Dr : StShDr;
      StEx1Dr: w_state_next = r_tms_ev ? StUpdDr : StPaDr;
      StPaDr:  w_state_next = r_tms_ev ? StEx2Dr : StPaDr;
      StEx2Dr: w_state_next = r_tms_ev ? StUpdDr : StShDr;
      StUpdDr: w_state_next = r_tms_ev ? StSelDr : StRti;
      StSelIr: w_state_next = r_tms_ev ? StTlr   : StCapIr;
      StCapIr: w_state_next = r_tms_ev ? StEx1Ir : StShIr;
      StShIr:  w_state_next = r_tms_ev ? StEx1Ir : StShIr;
      StEx1Ir: w_state_next = r_tms_ev ? StUpdIr : StPaIr;
      StPaIr:  w_state_next = r_tms_ev ? StEx2Ir : StPaIr;
      StEx2Ir: w_state_next = r_tms_ev ? StUpdIr : StShIr;
      StUpdIr: w_state_next = r_tms_ev ? StSelDr : StRti;
    endcase
  end

  // TAP FSM: per-event actions; capture/update fire on the rise that enters the state
  logic w_enter_tlr, w_cap_ir, w_shift_ir, w_upd_ir, w_cap_dr, w_shift_dr, w_upd_dr;
  logic w_in_shift_ir, w_in_shift_dr;

  always_comb begin
    w_enter_tlr   = r_rise & (w_state_next == StTlr);
    w_cap_ir      = r_rise & (w_state_next == StCapIr);
    w_upd_ir      = r_rise & (w_state_next == StUpdIr);
    w_cap_dr      = r_rise & (w_state_next == StCapDr);
    w_upd_dr      = r_rise & (w_state_next == StUpdDr);
    w_shift_ir    = r_rise & (r_state == StShIr);
    w_shift_dr    = r_rise & (r_state == StShDr);
    w_in_shift_ir = (r_state == StShIr);
    w_in_shift_dr = (r_state == StShDr);
  end

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [IR_WIDTH-1:0] r_ir, r_ir_sr;
  logic                w_sel_idcode, w_sel_user, w_sel_bypass;

  assign w_sel_idcode = (r_ir == IrIdcode);
  assign w_sel_user   = (r_ir == IrUser);
  assign w_sel_bypass = ~w_sel_idcode & ~w_sel_user;

  // ---------------------------------------------------------------------------
  // Instruction/data registers and outputs
  // ---------------------------------------------------------------------------
  logic [DR_WIDTH-1:0] r_dr_sr, r_upd_data;
  logic                r_cap_strobe, r_upd_valid, r_tdo, r_tdo_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ir         <= IrIdcode;
      r_ir_sr      <= '0;
      r_dr_sr      <= '0;
      r_upd_data   <= '0;
      r_cap_strobe <= 1'b0;
      r_upd_valid  <= 1'b0;
      r_tdo        <= 1'b0;
      r_tdo_en     <= 1'b0;
    end else if (w_trst) begin
      r_ir         <= IrIdcode;
      r_ir_sr      <= '0;
      r_dr_sr      <= '0;
      r_upd_data   <= '0;
      r_cap_strobe <= 1'b0;
      r_upd_valid  <= 1'b0;
      r_tdo        <= 1'b0;
      r_tdo_en     <= 1'b0;
    end else begin
      r_cap_strobe <= w_cap_dr & w_sel_user;
      r_upd_valid  <= w_upd_dr & w_sel_user;

      if (r_state == StTlr || w_enter_tlr) begin
        r_ir <= IrIdcode;
      end else if (w_upd_ir) begin
        r_ir <= r_ir_sr;
      end

      if (w_cap_ir) begin
        r_ir_sr <= IR_WIDTH'(1);
      end else if (w_shift_ir) begin
        r_ir_sr <= {r_tdi_ev, r_ir_sr[IR_WIDTH-1:1]};
      end

      if (w_cap_dr) begin
        if (w_sel_idcode)    r_dr_sr <= DR_WIDTH'(IDCODE);
        else if (w_sel_user) r_dr_sr <= cap_data;
        else                 r_dr_sr <= '0;
      end else if (w_shift_dr) begin
        // BYPASS is a 1-bit register living in bit 0
        if (w_sel_bypass) r_dr_sr[0] <= r_tdi_ev;
        else              r_dr_sr    <= {r_tdi_ev, r_dr_sr[DR_WIDTH-1:1]};
      end

      if (w_upd_dr && w_sel_user) r_upd_data <= r_dr_sr;

      if (r_fall) begin
        r_tdo_en <= w_in_shift_ir | w_in_shift_dr;
        if (w_in_shift_ir)      r_tdo <= r_ir_sr[0];
        else if (w_in_shift_dr) r_tdo <= r_dr_sr[0];
        else                    r_tdo <= 1'b0;
      end
    end
  end

  assign tdo        = r_tdo;
  assign tdo_en     = r_tdo_en;
  assign cap_strobe = r_cap_strobe;
  assign upd_valid  = r_upd_valid;
  assign upd_data   = r_upd_data;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: bitbangs TAP sequences and checks tdo, pulses and update data.
module tb_jtag_tap_sampled;

  logic        clk = 1'b0;
  logic        rstn, tck, tms, tdi, trst;
  logic        tdo, tdo_en, cap_strobe, upd_valid;
  logic [31:0] cap_data, upd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cap_cnt = 0, cap_run = 0, cap_max = 0;
  int upd_cnt = 0, upd_run = 0, upd_max = 0;

  jtag_tap_sampled dut (
    .clk       (clk),
    .rstn      (rstn),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .trst      (trst),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .cap_data  (cap_data),
    .cap_strobe(cap_strobe),
    .upd_data  (upd_data),
    .upd_valid (upd_valid)
  );

  always #5 clk = ~clk;

  // Pulse counters and longest high run for the two strobes
  always @(posedge clk) begin
    if (cap_strobe === 1'b1) begin
      cap_cnt++;
      cap_run++;
    end else begin
      cap_run = 0;
    end
    if (cap_run > cap_max) cap_max = cap_run;
    if (upd_valid === 1'b1) begin
      upd_cnt++;
      upd_run++;
    end else begin
      upd_run = 0;
    end
    if (upd_run > upd_max) upd_max = upd_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One tck period: tms/tdi set while low, tdo/tdo_en sampled just before the rise
  task automatic tck_cycle(input logic tms_v, input logic tdi_v,
                           output logic tdo_s, output logic en_s);
    tms = tms_v;
    tdi = tdi_v;
    wait_clk(5);
    tdo_s = tdo;
    en_s  = tdo_en;
    tck = 1'b1;
    wait_clk(5);
    tck = 1'b0;
  endtask

  task automatic tms_step(input logic tms_v);
    logic t, e;
    tck_cycle(tms_v, 1'b0, t, e);
  endtask

  // Shift n bits LSB-first; last bit leaves the shift state with tms=1
  task automatic shift(input int n, input logic [31:0] din,
                       output logic [31:0] dout, output logic en_all);
    logic t, e;
    dout   = '0;
    en_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      tck_cycle((i == n - 1), din[i], t, e);
      dout[i] = t;
      en_all  = en_all & e;
    end
  endtask

  // From Run-Test/Idle: load IR, return to Run-Test/Idle; dout is the captured IR
  task automatic load_ir(input logic [4:0] ir, output logic [31:0] dout);
    logic en;
    tms_step(1'b1);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift(5, {27'd0, ir}, dout, en);
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  logic [31:0] rd;
  logic        en_all, t, e;
  int          cap0, upd0;

  initial begin
    rstn = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0; trst = 1'b0;
    cap_data = 32'h0;
    wait_clk(4);
    rstn = 1'b1;
    wait_clk(4);
    check("rst_tdo", {31'd0, tdo}, 32'd0);
    check("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
    check("rst_cap_strobe", {31'd0, cap_strobe}, 32'd0);
    check("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
    check("rst_upd_data", upd_data, 32'd0);

    // IDCODE readout straight after reset
    tms_step(1'b0);
    tms_step(1'b1);
    tms_step(1'b0);
    tck_cycle(1'b0, 1'b0, t, e);
    check("idcode_en_before_shift", {31'd0, e}, 32'd0);
    shift(32, 32'h0, rd, en_all);
    check("idcode_data", rd, 32'h1000_0E1F);
    check("idcode_en_during_shift", {31'd0, en_all}, 32'd1);
    wait_clk(6);
    check("idcode_en_after_shift", {31'd0, tdo_en}, 32'd0);
    tms_step(1'b1);
    tms_step(1'b0);
    wait_clk(3);
    check("idcode_no_upd", upd_cnt, 0);

    // USER write
    load_ir(5'h11, rd);
    check("user_ir_capture", rd, 32'h0000_0001);
    cap0 = cap_cnt;
    upd0 = upd_cnt;
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift(32, 32'hDEAD_BEEF, rd, en_all);
    tms_step(1'b1);
    tms_step(1'b0);
    wait_clk(3);
    check("user_wr_upd_cnt", upd_cnt - upd0, 1);
    check("user_wr_upd_data", upd_data, 32'hDEAD_BEEF);
    check("user_wr_cap_cnt", cap_cnt - cap0, 1);

    // USER read
    cap_data = 32'h1234_5678;
    cap0 = cap_cnt;
    upd0 = upd_cnt;
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift(32, 32'hCAFE_F00D, rd, en_all);
    check("user_rd_data", rd, 32'h1234_5678);
    check("user_rd_cap_cnt", cap_cnt - cap0, 1);
    check("user_rd_upd_hold", upd_data, 32'hDEAD_BEEF);
    tms_step(1'b1);
    tms_step(1'b0);
    wait_clk(3);
    check("user_rd_upd_data", upd_data, 32'hCAFE_F00D);
    check("user_rd_upd_cnt", upd_cnt - upd0, 1);

    // Unknown IR behaves as BYPASS: tdo is tdi delayed one tck, first bit 0
    load_ir(5'h07, rd);
    check("bypass_ir_capture", rd, 32'h0000_0001);
    upd0 = upd_cnt;
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift(8, 32'h0000_00A5, rd, en_all);
    check("bypass_data", rd, 32'h0000_004A);
    tms_step(1'b1);
    tms_step(1'b0);
    wait_clk(3);
    check("bypass_no_upd", upd_cnt - upd0, 0);

    // TMS reset from mid Shift-DR
    upd0 = upd_cnt;
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    for (int i = 0; i < 3; i++) tms_step(1'b0);
    for (int i = 0; i < 5; i++) tms_step(1'b1);
    wait_clk(6);
    check("tmsrst_tdo_en", {31'd0, tdo_en}, 32'd0);
    check("tmsrst_no_upd", upd_cnt - upd0, 0);
    tms_step(1'b0);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift(32, 32'h0, rd, en_all);
    check("tmsrst_idcode", rd, 32'h1000_0E1F);
    tms_step(1'b1);
    tms_step(1'b0);

    // trst asserted mid Shift-IR with USER selected
    load_ir(5'h11, rd);
    tms_step(1'b1);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    tck_cycle(1'b0, 1'b1, t, e);
    tck_cycle(1'b0, 1'b1, t, e);
    check("trst_en_before", {31'd0, e}, 32'd1);
    cap0 = cap_cnt;
    trst = 1'b1;
    wait_clk(4);
    trst = 1'b0;
    wait_clk(5);
    check("trst_tdo", {31'd0, tdo}, 32'd0);
    check("trst_tdo_en", {31'd0, tdo_en}, 32'd0);
    check("trst_upd_data", upd_data, 32'd0);
    check("trst_upd_valid", {31'd0, upd_valid}, 32'd0);
    check("trst_cap_strobe", {31'd0, cap_strobe}, 32'd0);
    tms_step(1'b0);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    shift(32, 32'h0, rd, en_all);
    check("trst_idcode", rd, 32'h1000_0E1F);
    check("trst_no_cap", cap_cnt - cap0, 0);
    tms_step(1'b1);
    tms_step(1'b0);
    wait_clk(3);

    check("cap_pulse_width", cap_max, 1);
    check("upd_pulse_width", upd_max, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sampled.md
# jtag_tap_sampled

Oversampled JTAG TAP controller: the responder end of the JTAG link driven by the simulation bitbang master (SimDpiJtag) or an external probe. It runs entirely on the CPU system clock. It synchronizes the asynchronous `tck`/`tms`/`tdi`/`trst` pins, detects `tck` edges, and runs the IEEE 1149.1 16-state TAP FSM. It exposes IDCODE, BYPASS and one 32-bit USER data register with a parallel capture/update handshake toward the CPU debug module.

## Interface
- `IR_WIDTH`, 5, instruction register width.
- `DR_WIDTH`, 32, USER data register width.
- `IDCODE`, 32'h1000_0E1F, value shifted out by IDCODE (bit 0 must be 1).
- `clk`  input  1  system clock; all state on rising edge.
- `rstn`  input  1  asynchronous active-low reset.
- `tck`  input  1  JTAG clock; asynchronous, sampled by `clk`.
- `tms`  input  1  JTAG mode select; asynchronous.
- `tdi`  input  1  JTAG data in; asynchronous.
- `trst`  input  1  JTAG reset, active-high (board drives `~trstn`); asynchronous.
- `tdo`  output  1  JTAG data out.
- `tdo_en`  output  1  high while in Shift-IR or Shift-DR.
- `cap_data`  input  DR_WIDTH  parallel value loaded at Capture-DR of USER.
- `cap_strobe`  output  1  one-cycle pulse when `cap_data` is sampled.
- `upd_data`  output  DR_WIDTH  USER shift register contents at Update-DR.
- `upd_valid`  output  1  one-cycle pulse at Update-DR of USER.

## Operation
- Synchronizer: each of `tck`, `tms`, `tdi`, `trst` goes through a 2-flop synchronizer. `tck_prev` holds the previous synced `tck`.
- Edge events: `rise` = synced tck & ~tck_prev; `fall` = ~synced tck & tck_prev. All TAP actions happen only on clk edges where an event is true.
- FSM: 16 standard states, encoded 4-bit, standard TMS transitions, evaluated on `rise` using synced `tms`.
- IR: holds IDCODE opcode 5'h01 in Test-Logic-Reset.
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts LSB-first; `tdi` enters the MSB.
  - Update-IR copies the shift register to IR.
- Decode:
  - 5'h01 IDCODE.
  - 5'h11 USER.
  - 5'h1F and all other codes BYPASS.
- Capture-DR by instruction:
  - IDCODE loads `IDCODE`.
  - USER loads `cap_data` and pulses `cap_strobe`.
  - BYPASS loads 1'b0.
- Shift-DR: shifts the selected register LSB-first; BYPASS is a 1-bit register.
- Update-DR (USER only): `upd_data` takes the shift register value and `upd_valid` pulses for one clk. `upd_data` holds until the next update.
- `tdo`/`tdo_en`: updated on `fall`.
  - In Shift-IR/Shift-DR: `tdo` = shift register bit 0 and `tdo_en` = 1.
  - Otherwise: `tdo` = 0 and `tdo_en` = 0.
- Reset sources: `rstn` low (asynchronous), or synced `trst` high (synchronous to `clk`). Either source forces:
  - state = Test-Logic-Reset, IR = 5'h01, all shift registers = 0;
  - `tdo` = 0, `tdo_en` = 0, `cap_strobe` = 0, `upd_valid` = 0, `upd_data` = 0.
- Entering Test-Logic-Reset via TMS also sets IR = 5'h01. It does not clear `upd_data`.

## Timing
- Event latency: a `tck` edge first sampled at clk edge k produces the FSM/shift update at clk edge k+3. The same latency applies to the `tdo` change.
- `tck` high and low phases must each be ≥4 clk periods. `tms`/`tdi` must be stable ≥3 clk periods before the `tck` rising edge.
- Pulse timing: `cap_strobe` and `upd_valid` assert in the clk cycle after the `rise` that enters Capture-DR / Update-DR, and last exactly 1 clk.
- Priority: synced `trst` high overrides a simultaneous `rise`/`fall`. Reset mid-shift discards the partial shift, with no `upd_valid`.
- Idle: `rise` and `fall` cannot both be true in one cycle. Without edges the outputs hold.

## Configuration
- `JTAG_TAP_GLITCH_FILTER_EN`:
  - Defined: a third synchronizer stage is added, and synced `tck` changes only when the last two stage outputs agree. A single-clk `tck` pulse is ignored, event latency becomes k+4, and the minimum `tck` phase becomes 5 clk periods.
  - Undefined: behaviour exactly as above.

## Test plan
- Reset then IDCODE readout: `rstn` low, release, TMS path to Shift-DR, shift 32 bits → `tdo` sequence LSB-first equals 32'h1000_0E1F; `tdo_en` = 1 only during shift.
- TMS reset: from Shift-DR mid-shift, 5 rises with `tms`=1 → state Test-Logic-Reset, IR = 5'h01, no `upd_valid`.
- USER write: load IR 5'h11, shift 32'hDEADBEEF → single `upd_valid` pulse with `upd_data` = 32'hDEADBEEF.
- USER read: `cap_data` = 32'h12345678, Capture-DR → one `cap_strobe` pulse; shifted-out bits = 32'h12345678.
- BYPASS/unknown IR: IR 5'h07, shift 8 bits 8'hA5 → `tdo` equals `tdi` delayed by 1 `tck`, first bit 0.
- `trst` mid-Shift-IR: assert `trst` for 4 clk → all outputs at reset values; next Capture-DR yields IDCODE.
